// File: rtl/piradip_s2sym_pkg.sv
// Shared helpers and types for the stream-to-symbol splitter.
// The optional sym_last path is controlled by PIRADIP_S2SYM_LAST_EN.
package piradip_s2sym_pkg;

   localparam int S2SYM_DEF_WIDTH = 32;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } s2sym_state_t;

   // Default buffered-word layout; the top builds its own WIDTH-sized copy.
   typedef struct packed {
      logic [S2SYM_DEF_WIDTH-1:0] data;
      logic                       last;
   } s2sym_word_t;

   function automatic int sym_count(input int width, input int sym_width);
      return width / sym_width;
   endfunction

   function automatic int idx_width(input int width, input int sym_width);
      int syms;
      syms = width / sym_width;
      return (syms > 1) ? $clog2(syms) : 1;
   endfunction

endpackage

// File: rtl/piradip_s2sym_prefetch.sv
// Single-entry prefetch register: holds the next word while the current
// one is still being split into symbols.
module piradip_s2sym_prefetch
   import piradip_s2sym_pkg::*;
#(
   parameter type word_t = s2sym_word_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_load,
   input  word_t i_word,
   input  logic  i_take,
   output logic  o_valid,
   output word_t o_word
);

   logic  r_valid;
   word_t r_word;

   // Load and take are never asserted together: a load needs the entry empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_word  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_word  <= i_word;
      end else if (i_take) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_word  = r_word;

endmodule

// File: rtl/piradip_stream_to_symbol.sv
// Splits WIDTH-bit stream words into SYM_WIDTH-bit symbols, one per clock.
// Define PIRADIP_S2SYM_LAST_EN to add word_last / sym_last.
module piradip_stream_to_symbol
   import piradip_s2sym_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SYM_WIDTH = 1,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IDX_W    = idx_width(WIDTH, SYM_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 align,
   input  logic [WIDTH-1:0]     word_data,
   input  logic                 word_valid,
   output logic                 word_ready,
`ifdef PIRADIP_S2SYM_LAST_EN
   input  logic                 word_last,
   output logic                 sym_last,
`endif
   output logic [SYM_WIDTH-1:0] sym_data,
   output logic                 sym_valid,
   input  logic                 sym_ready,
   output logic [IDX_W-1:0]     sym_index
);

   localparam int              SYMS     = sym_count(WIDTH, SYM_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

   generate
      if (SYM_WIDTH < 1 || SYM_WIDTH > WIDTH || (WIDTH % SYM_WIDTH) != 0) begin : g_bad_cfg
         $error("piradip_stream_to_symbol: WIDTH must be a multiple of SYM_WIDTH");
      end
   endgenerate

`ifdef PIRADIP_S2SYM_LAST_EN
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } word_t;
`else
   typedef struct packed {
      logic [WIDTH-1:0] data;
   } word_t;
`endif

   s2sym_state_t     r_state;
   s2sym_state_t     w_state_next;
   word_t            r_buf;
   word_t            w_buf_next;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_cnt_next;

   word_t w_in_word;
   word_t w_pre_word;
   logic  w_pre_v;
   logic  w_act;
   logic  w_sym_hs;
   logic  w_word_rdy;
   logic  w_word_acc;
   logic  w_at_last;
   logic  w_done;
   logic  w_pre_load;
   logic  w_pre_take;

   assign w_in_word.data = word_data;
`ifdef PIRADIP_S2SYM_LAST_EN
   assign w_in_word.last = word_last;
`endif

   assign w_act      = (r_state == S_ACTIVE);
   assign w_sym_hs   = w_act & sym_ready;
   assign w_word_rdy = ~w_pre_v & ~rst;
   assign w_word_acc = word_valid & w_word_rdy;
   assign w_at_last  = (r_cnt == LAST_IDX);
   // Word finished: last symbol taken, or align drops whatever is left.
   assign w_done     = w_act & ((w_sym_hs & w_at_last) | align);
   assign w_pre_load = w_word_acc & w_act & ~w_done;
   assign w_pre_take = w_done & w_pre_v;

   piradip_s2sym_prefetch #(
      .word_t (word_t)
   ) u_prefetch (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_pre_load),
      .i_word  (w_in_word),
      .i_take  (w_pre_take),
      .o_valid (w_pre_v),
      .o_word  (w_pre_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_buf   <= w_buf_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_buf_next   = r_buf;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_word_acc) begin
               w_state_next = S_ACTIVE;
               w_buf_next   = w_in_word;
               w_cnt_next   = '0;
            end
         end
         S_ACTIVE: begin
            if (w_done) begin
               w_cnt_next = '0;
               if (w_pre_v) begin
                  w_buf_next = w_pre_word;
               end else if (w_word_acc) begin
                  w_buf_next = w_in_word;
               end else begin
                  // Clearing the buffer also drops the stored last flag.
                  w_state_next = S_IDLE;
                  w_buf_next   = '0;
               end
            end else if (w_sym_hs) begin
               w_buf_next.data = MSB_FIRST ? (r_buf.data << SYM_WIDTH)
                                           : (r_buf.data >> SYM_WIDTH);
               w_cnt_next      = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < SYM_WIDTH; gi++) begin : g_sym_bit
         assign sym_data[gi] = MSB_FIRST ? r_buf.data[WIDTH-SYM_WIDTH+gi] : r_buf.data[gi];
      end
   endgenerate

   assign sym_valid  = w_act;
   assign sym_index  = r_cnt;
   assign word_ready = w_word_rdy;
`ifdef PIRADIP_S2SYM_LAST_EN
   assign sym_last   = r_buf.last & w_at_last & w_act;
`endif

endmodule

// File: tb/tb_piradip_stream_to_symbol.sv
// Randomized bench: three splitter configurations share one stimulus stream,
// each compared against a word-queue reference model.
module tb_piradip_stream_to_symbol;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        align = 1'b0;
   logic [31:0] word_data = '0;
   logic        word_valid = 1'b0;
   logic        word_last = 1'b0;
   logic        sym_ready = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] dir_words [6];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_sym(input logic [31:0] w, input int sw, input bit mf, input int pos);
      logic [63:0] mask;
      int          sh;
      mask = (64'd1 << sw) - 64'd1;
      sh   = mf ? (32 - (pos + 1) * sw) : (pos * sw);
      return (64'(w) >> sh) & mask;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cfg
         localparam int SW   = (gi == 0) ? 1 : ((gi == 1) ? 4 : 32);
         localparam bit MF   = (gi != 1);
         localparam int SYMS = 32 / SW;
         localparam int IW   = (SYMS > 1) ? $clog2(SYMS) : 1;

         logic          w_word_ready;
         logic          w_sym_valid;
         logic [SW-1:0] w_sym_data;
         logic [IW-1:0] w_sym_index;
`ifdef PIRADIP_S2SYM_LAST_EN
         logic          w_sym_last;
`endif

         piradip_stream_to_symbol #(
            .WIDTH     (32),
            .SYM_WIDTH (SW),
            .MSB_FIRST (MF)
         ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .align      (align),
            .word_data  (word_data),
            .word_valid (word_valid),
            .word_ready (w_word_ready),
`ifdef PIRADIP_S2SYM_LAST_EN
            .word_last  (word_last),
            .sym_last   (w_sym_last),
`endif
            .sym_data   (w_sym_data),
            .sym_valid  (w_sym_valid),
            .sym_ready  (sym_ready),
            .sym_index  (w_sym_index)
         );

         // Reference: queue of accepted words; the front word is being emitted
         // at symbol position mpos. At most two words are ever outstanding.
         logic [31:0] mq[$];
         bit          ml[$];
         int          mpos = 0;
         bit          m_vexp, m_hs, m_acc, m_popped;

         always @(posedge clk or posedge rst) begin
            if (rst) begin
               mq.delete();
               ml.delete();
               mpos = 0;
            end else begin
               m_vexp   = (mq.size() > 0);
               m_hs     = m_vexp && sym_ready;
               m_acc    = word_valid && (mq.size() < 2);
               m_popped = 1'b0;
               if (m_hs) begin
                  mpos++;
                  if (mpos == SYMS) begin
                     void'(mq.pop_front());
                     void'(ml.pop_front());
                     mpos     = 0;
                     m_popped = 1'b1;
                  end
               end
               if (align && m_vexp && !m_popped) begin
                  void'(mq.pop_front());
                  void'(ml.pop_front());
                  mpos = 0;
               end
               if (m_acc) begin
                  mq.push_back(word_data);
                  ml.push_back(word_last);
               end
            end
         end

         always @(negedge clk) begin
            chk($sformatf("c%0d.valid", gi), 64'(w_sym_valid), 64'(mq.size() > 0));
            chk($sformatf("c%0d.ready", gi), 64'(w_word_ready), 64'(!rst && mq.size() < 2));
            if (rst) begin
               chk($sformatf("c%0d.rst_data", gi), 64'(w_sym_data), 64'd0);
               chk($sformatf("c%0d.rst_index", gi), 64'(w_sym_index), 64'd0);
            end else if (mq.size() > 0) begin
               chk($sformatf("c%0d.data", gi), 64'(w_sym_data), exp_sym(mq[0], SW, MF, mpos));
               chk($sformatf("c%0d.index", gi), 64'(w_sym_index), 64'(mpos));
`ifdef PIRADIP_S2SYM_LAST_EN
               chk($sformatf("c%0d.last", gi), 64'(w_sym_last), 64'(ml[0] && mpos == SYMS - 1));
`endif
            end
         end

         // Asynchronous reset must clear the outputs without waiting for a clock.
         always @(posedge rst) begin
            #1;
            chk($sformatf("c%0d.arst_valid", gi), 64'(w_sym_valid), 64'd0);
            chk($sformatf("c%0d.arst_ready", gi), 64'(w_word_ready), 64'd0);
         end
      end
   endgenerate

   task automatic run_cycles(input int n, input int pv, input int pr, input int pa, input bit dir);
      for (int k = 0; k < n; k++) begin
         word_valid = ($urandom_range(0, 99) < pv);
         word_data  = dir ? dir_words[k % 6] : $urandom;
         word_last  = $urandom_range(0, 1);
         sym_ready  = ($urandom_range(0, 99) < pr);
         align      = ($urandom_range(0, 99) < pa);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      dir_words[0] = 32'hA5A5A5A5;
      dir_words[1] = 32'h76543210;
      dir_words[2] = 32'hFEDCBA98;
      dir_words[3] = 32'hCCDDEEFF;
      dir_words[4] = 32'hCCCCCCCC;
      dir_words[5] = 32'hDDDDDDDD;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Known words at full rate, then with backpressure, then with align.
      run_cycles(200, 100, 100, 0, 1'b1);
      run_cycles(200, 100, 50, 0, 1'b1);
      run_cycles(300, 70, 80, 4, 1'b1);

      // Mid-word asynchronous reset.
      run_cycles(40, 100, 100, 0, 1'b0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_cycles(1500, 60, 70, 3, 1'b0);
      run_cycles(500, 100, 100, 0, 1'b0);
      run_cycles(500, 30, 30, 10, 1'b0);

      word_valid = 1'b0;
      align      = 1'b0;
      sym_ready  = 1'b1;
      repeat (80) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
